// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two requesters.
// Operands are registered, the result is captured one cycle later and held until accepted.
module alu_share_arbiter #(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [3:0]       req0_sel,
  input  logic [3:0]       req1_sel,
  input  logic [N-1:0]     req0_a,
  input  logic [N-1:0]     req0_b,
  input  logic [N-1:0]     req1_a,
  input  logic [N-1:0]     req1_b,
  input  logic [4:0]       req0_shamt,
  input  logic [4:0]       req1_shamt,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [N-1:0]     rsp_result,
  output logic [3:0]       rsp_flags,
  output logic [3:0]       alu_sel,
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  output logic [4:0]       alu_shamt,
  input  logic [N-1:0]     alu_out,
  input  logic             alu_negative,
  input  logic             alu_zero,
  input  logic             alu_cout,
  input  logic             alu_overflow,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  typedef struct packed {
    logic [3:0]   sel;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [4:0]   shamt;
  } op_t;

  state_e           state_q, state_d;
  op_t              op_q, op_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [N-1:0]     res_q, res_d;
  logic [3:0]       flg_q, flg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gnt;

  // On a tie the requester that was not served last wins
  always_comb begin
    gnt = 1'b0;
    unique case (req_valid)
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = ~last_q;
      default: gnt = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    owner_d   = owner_q;
    last_d    = last_q;
    res_d     = res_q;
    flg_d     = flg_q;
    cnt_d     = cnt_q;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready = gnt ? 2'b10 : 2'b01;
          owner_d   = gnt;
          state_d   = EXEC;
          op_d      = gnt ?
            op_t'{req1_sel, req1_a, req1_b, req1_shamt} :
            op_t'{req0_sel, req0_a, req0_b, req0_shamt};
        end
      end
      EXEC: begin
        res_d   = alu_out;
        flg_d   = {alu_negative, alu_zero,
                   alu_cout, alu_overflow};
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = owner_q ? 2'b10 : 2'b01;
        if (rsp_ready[owner_q]) begin
          last_d  = owner_q;
          state_d = IDLE;
          if (cnt_q != {CNT_W{1'b1}})
            cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      res_q   <= '0;
      flg_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign alu_sel    = op_q.sel;
  assign alu_a      = op_q.a;
  assign alu_b      = op_q.b;
  assign alu_shamt  = op_q.shamt;
  assign rsp_result = res_q;
  assign rsp_flags  = flg_q;
  assign busy       = (state_q != IDLE);
  assign ops_done   = cnt_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_alu_share_arbiter;

  localparam int N = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    req_valid = '0;
  logic [1:0]    rsp_ready = '0;
  logic [3:0]    s0 = '0, s1 = '0;
  logic [N-1:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [4:0]    h0 = '0, h1 = '0;

  logic [1:0]    req_ready, rsp_valid, req_ready2, rsp_valid2;
  logic [N-1:0]  rsp_result, rsp_result2;
  logic [3:0]    rsp_flags, rsp_flags2;
  logic [3:0]    alu_sel, alu_sel2;
  logic [N-1:0]  alu_a, alu_b, alu_a2, alu_b2, alu_out, alu_out2;
  logic [4:0]    alu_shamt, alu_shamt2;
  logic          an, az, ac, av, an2, az2, ac2, av2;
  logic          busy, busy2;
  logic [15:0]   ops_done;
  logic [1:0]    ops_done2;

  always #5 clk = ~clk;

  // Reference ALU: returns {neg, zero, cout, ovf, result}
  function automatic logic [N+3:0] ref_alu(
    input logic [3:0] s, input logic [N-1:0] a,
    input logic [N-1:0] b, input logic [4:0] sh);
    logic [N:0] w;
    logic [N-1:0] r;
    logic c, v;
    w = '0; r = '0; c = 1'b0; v = 1'b0;
    case (s)
      4'd0: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[N-1:0]; c = w[N];
        v = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
      end
      4'd1: begin
        w = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = w[N-1:0]; c = w[N];
        v = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << sh;
      4'd6: r = a >> sh;
      default: r = '0;
    endcase
    return {r[N-1], (r == '0), c, v, r};
  endfunction

  assign {an, az, ac, av, alu_out} =
    ref_alu(alu_sel, alu_a, alu_b, alu_shamt);
  assign {an2, az2, ac2, av2, alu_out2} =
    ref_alu(alu_sel2, alu_a2, alu_b2, alu_shamt2);

  alu_share_arbiter #(.N(N), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_sel(s0), .req1_sel(s1),
    .req0_a(a0), .req0_b(b0), .req1_a(a1), .req1_b(b1),
    .req0_shamt(h0), .req1_shamt(h1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
    .alu_shamt(alu_shamt), .alu_out(alu_out),
    .alu_negative(an), .alu_zero(az),
    .alu_cout(ac), .alu_overflow(av),
    .busy(busy), .ops_done(ops_done));

  alu_share_arbiter #(.N(N), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready2),
    .req0_sel(s0), .req1_sel(s1),
    .req0_a(a0), .req0_b(b0), .req1_a(a1), .req1_b(b1),
    .req0_shamt(h0), .req1_shamt(h1),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result2), .rsp_flags(rsp_flags2),
    .alu_sel(alu_sel2), .alu_a(alu_a2), .alu_b(alu_b2),
    .alu_shamt(alu_shamt2), .alu_out(alu_out2),
    .alu_negative(an2), .alu_zero(az2),
    .alu_cout(ac2), .alu_overflow(av2),
    .busy(busy2), .ops_done(ops_done2));

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    else
      n_pass++;
  endtask

  // Transaction model: one op in flight, visible one cycle after issue
  bit           armed = 0;
  bit           inflight = 0;
  bit           age = 0;
  bit           owner = 0;
  bit           last = 1;
  int           done = 0;
  logic [N-1:0] ea = '0, eb = '0;
  logic [8:0]   esel = '0;
  logic [N+3:0] erSP = '0;

  function automatic bit pick(input logic [1:0] v, input bit lst);
    if (v == 2'b11) return !lst;
    return v[1] && !v[0];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      armed = 1; inflight = 0; age = 0; done = 0; last = 1;
      ea = '0; eb = '0; esel = '0;
    end else if (!inflight) begin
      if (|req_valid) begin
        owner = pick(req_valid, last);
        inflight = 1; age = 0;
        ea   = owner ? a1 : a0;
        eb   = owner ? b1 : b0;
        esel = owner ? {s1, h1} : {s0, h0};
        erSP = ref_alu(esel[8:5], ea, eb, esel[4:0]);
      end
    end else if (!age) begin
      age = 1;
    end else if (rsp_ready[owner]) begin
      inflight = 0; last = owner; done++;
    end
  end

  always @(negedge clk) begin
    logic [1:0] er, ev;
    if (armed) begin
      er = (!inflight && |req_valid) ?
           (pick(req_valid, last) ? 2'b10 : 2'b01) : 2'b00;
      ev = (inflight && age) ? (owner ? 2'b10 : 2'b01) : 2'b00;
      chk("m_busy", busy, inflight);
      chk("m_req_ready", req_ready, er);
      chk("m_rsp_valid", rsp_valid, ev);
      chk("m_ops_done", ops_done, (done > 65535) ? 65535 : done);
      chk("m_ops_done_w2", ops_done2, (done > 3) ? 3 : done);
      chk("m_rsp_valid_w2", rsp_valid2, ev);
      chk("m_alu_a", alu_a, ea);
      chk("m_alu_b", alu_b, eb);
      chk("m_alu_sel_sh", {alu_sel, alu_shamt}, esel);
      if (ev != 2'b00) begin
        chk("m_result", rsp_result, erSP[N-1:0]);
        chk("m_flags", rsp_flags, erSP[N+3:N]);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [1:0] grants[$];

  initial begin
    // reset
    rst = 1; tick(2); rst = 0; #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_ops", ops_done, 16'd0);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_alu_a", alu_a, 32'd0);

    // single add on port 0
    s0 = 4'd0; a0 = 32'd59; b0 = 32'd77; req_valid = 2'b01; #1;
    chk("add_ready", req_ready, 2'b01);
    tick; req_valid = 2'b00;
    tick; #1;
    chk("add_valid", rsp_valid, 2'b01);
    chk("add_result", rsp_result, 32'd136);
    chk("add_flags", rsp_flags, 4'b0000);
    rsp_ready = 2'b01; tick; rsp_ready = 2'b00; #1;
    chk("add_ops", ops_done, 16'd1);
    chk("add_idle", busy, 1'b0);

    // overflowing add on port 1
    s1 = 4'd0; a1 = 32'h8000_0000; b1 = 32'h8000_0000;
    req_valid = 2'b10; #1;
    chk("ovf_ready", req_ready, 2'b10);
    tick; req_valid = 2'b00;
    tick; #1;
    chk("ovf_valid", rsp_valid, 2'b10);
    chk("ovf_result", rsp_result, 32'd0);
    chk("ovf_flags", rsp_flags, 4'b0111);
    rsp_ready = 2'b10; tick; rsp_ready = 2'b00;

    // contention from reset, responses always accepted
    s0 = 4'd1; a0 = 32'd100; b0 = 32'd1;
    s1 = 4'd4; a1 = 32'hFFFF_0000; b1 = 32'h0F0F_0F0F;
    req_valid = 2'b11; rsp_ready = 2'b11;
    rst = 1; tick; rst = 0;
    for (int k = 0; k < 15; k++) begin
      #1;
      if (req_ready != 2'b00) grants.push_back(req_ready);
      if (k == 9) chk("sat_after3", ops_done2, 2'd3);
      if (k == 12) begin
        chk("cont_ops4", ops_done, 16'd4);
        chk("sat_after4", ops_done2, 2'd3);
      end
      tick;
    end
    req_valid = 2'b00; rsp_ready = 2'b00; #1;
    chk("cont_ops5", ops_done, 16'd5);
    chk("sat_after5", ops_done2, 2'd3);
    chk("cont_ngrants", grants.size(), 5);
    for (int i = 0; i < grants.size(); i++)
      chk("cont_order", grants[i], (i % 2) ? 2'b10 : 2'b01);

    // response backpressure with port 1 waiting
    s0 = 4'd2; a0 = 32'hF0F0_1234; b0 = 32'h0FF0_FFFF; h0 = 5'd3;
    req_valid = 2'b01; #1;
    chk("bp_ready0", req_ready, 2'b01);
    tick;
    s1 = 4'd1; a1 = 32'd5; b1 = 32'd9; req_valid = 2'b10; #1;
    chk("bp_exec_ready", req_ready, 2'b00);
    tick;
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_ready", req_ready, 2'b00);
      chk("bp_hold_valid", rsp_valid, 2'b01);
      chk("bp_hold_result", rsp_result, 32'h00F0_1234);
      chk("bp_hold_flags", rsp_flags, 4'b0000);
      chk("bp_hold_alu_a", alu_a, 32'hF0F0_1234);
      chk("bp_hold_sh", alu_shamt, 5'd3);
      tick;
    end
    rsp_ready = 2'b11; #1;
    chk("bp_accept_ready", req_ready, 2'b00);
    tick; rsp_ready = 2'b00; #1;
    chk("bp_grant1", req_ready, 2'b10);
    tick; req_valid = 2'b00;
    tick; #1;
    chk("sub_valid", rsp_valid, 2'b10);
    chk("sub_result", rsp_result, 32'hFFFF_FFFC);
    chk("sub_flags", rsp_flags, 4'b1000);
    rsp_ready = 2'b10; tick; rsp_ready = 2'b00;

    // reset while the op is in EXEC
    s0 = 4'd0; a0 = 32'd1; b0 = 32'd2; req_valid = 2'b01;
    tick; req_valid = 2'b00; #1;
    chk("mid_busy", busy, 1'b1);
    rst = 1; tick; #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_valid", rsp_valid, 2'b00);
    chk("mid_rst_ops", ops_done, 16'd0);
    rst = 0;
    s0 = 4'd5; a0 = 32'd3; h0 = 5'd4; req_valid = 2'b01;
    tick; req_valid = 2'b00;
    tick; #1;
    chk("post_valid", rsp_valid, 2'b01);
    chk("post_result", rsp_result, 32'h30);
    rsp_ready = 2'b01; tick; rsp_ready = 2'b00; #1;
    chk("post_ops", ops_done, 16'd1);
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
